// File: rtl/pwm_peripheral_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_peripheral_pkg
// Brief    : Shared constants and helpers for the PWM peripheral.
// Revision : 1.0
// ============================================================================
package pwm_peripheral_pkg;

    localparam int c_clk_div      = 13;
    localparam int c_pwm_bits     = 8;
    localparam int c_num_channels = 16;

    // Prescaler width; a divide-by-1 still needs one bit to declare the register.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module   : pwm_timebase
// Brief    : Clock prescaler and free-running PWM counter with period pulse.
// Revision : 1.0
// ============================================================================
module pwm_timebase
    import pwm_peripheral_pkg::*;
#(
    parameter int CLK_DIV  = c_clk_div,
    parameter int PWM_BITS = c_pwm_bits
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                step_tick,
    output logic [PWM_BITS-1:0] count,
    output logic                period_start
);

    localparam int                   c_presc_w    = presc_width(CLK_DIV);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0]  c_count_last = '1;

    logic [c_presc_w-1:0] r_presc;
    logic [PWM_BITS-1:0]  r_count;
    logic                 w_step;

    assign w_step = (r_presc == c_presc_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_count <= '0;
        end else begin
            r_presc <= w_step ? '0 : r_presc + 1'b1;
            if (w_step) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Boundary is decoded from registers, so it clears with them on reset.
    assign step_tick    = w_step;
    assign count        = r_count;
    assign period_start = w_step & (r_count == c_count_last);

endmodule
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : pwm_peripheral
// Brief    : 16-channel static/PWM output block with a shared, period-aligned duty.
// Revision : 1.0
// ============================================================================
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int CLK_DIV  = c_clk_div,
    parameter int PWM_BITS = c_pwm_bits
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                en_reg_out_7_0,
    input  logic [7:0]                en_reg_out_15_8,
    input  logic [7:0]                en_reg_pwm_7_0,
    input  logic [7:0]                en_reg_pwm_15_8,
    input  logic [PWM_BITS-1:0]       pwm_duty_cycle,
    output logic [c_num_channels-1:0] out,
    output logic                      period_start
);

    localparam logic [PWM_BITS-1:0] c_duty_full = '1;

    logic                      w_unused_step_tick;
    logic [PWM_BITS-1:0]       w_count;
    logic                      w_period_start;
    logic [PWM_BITS-1:0]       r_shadow;
    logic                      w_pwm_sig;
    logic [c_num_channels-1:0] w_en_out;
    logic [c_num_channels-1:0] w_en_pwm;
    logic [c_num_channels-1:0] w_out_next;
    logic [c_num_channels-1:0] r_out;

    pwm_timebase #(
        .CLK_DIV  (CLK_DIV),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .step_tick    (w_unused_step_tick),
        .count        (w_count),
        .period_start (w_period_start)
    );

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_period_start) begin
            r_shadow <= pwm_duty_cycle;
        end
    end

    // Full-scale duty is forced high so the last counter step does not dip low.
    assign w_pwm_sig = (r_shadow == c_duty_full) | (w_count < r_shadow);

    for (genvar i = 0; i < c_num_channels; i++) begin : g_ch
        assign w_out_next[i] = w_en_out[i] & (~w_en_pwm[i] | w_pwm_sig);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign out          = r_out;
    assign period_start = w_period_start;

endmodule
`default_nettype wire

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter CLK_DIV, default 13, meaning clk cycles per PWM counter step (10 MHz / 13 / 256 ≈ 3.0 kHz).
REQ-002 SHALL have parameter PWM_BITS, default 8, meaning PWM counter and duty width.
REQ-003 SHALL have port clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en_reg_out_7_0  input  8  output enable for channels 7..0.
REQ-006 SHALL have port en_reg_out_15_8  input  8  output enable for channels 15..8.
REQ-007 SHALL have port en_reg_pwm_7_0  input  8  PWM mode select for channels 7..0.
REQ-008 SHALL have port en_reg_pwm_15_8  input  8  PWM mode select for channels 15..8.
REQ-009 SHALL have port pwm_duty_cycle  input  8  requested duty, shared by all PWM channels.
REQ-010 SHALL have port out  output  16  registered channel outputs; bit i is channel i.
REQ-011 SHALL have port period_start  output  1  one-clk pulse at every PWM period boundary.

Function
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 and wrap, asserting an internal step tick on the cycle it equals CLK_DIV-1.
REQ-013 PWM counter (PWM_BITS wide) SHALL increment only on step tick and SHALL wrap 255 -> 0 with no lost or extra state.
REQ-014 Period boundary SHALL be the step tick on which the PWM counter wraps 255 -> 0; period_start SHALL be high for exactly that one clk.
REQ-015 Period SHALL be exactly CLK_DIV*256 clk cycles.
REQ-016 Duty shadow register SHALL load pwm_duty_cycle only at the period boundary; mid-period input changes SHALL have no effect until the next period.
REQ-017 Internal pwm_sig SHALL be 1 when counter < shadow, else 0.
REQ-018 Shadow = 0x00 SHALL give pwm_sig constantly 0.
REQ-019 Shadow = 0xFF SHALL give pwm_sig constantly 1 (no 1/256 low glitch).
REQ-020 Channel i next value SHALL be: en_out[i]=0 -> 0; en_out[i]=1 and en_pwm[i]=0 -> 1; en_out[i]=1 and en_pwm[i]=1 -> pwm_sig.
REQ-021 en_pwm[i]=1 with en_out[i]=0 SHALL give 0 (output enable dominates).
REQ-022 Enable inputs SHALL take effect with exactly 1 clk latency (no period alignment).
REQ-023 out SHALL be registered; out changes SHALL lag the counter/shadow state that caused them by exactly 1 clk.
REQ-024 All PWM-mode channels SHALL switch on the same clk edge (no per-channel skew).
REQ-025 Inputs SHALL be treated as synchronous to clk and stable registers; no synchronisers SHALL be added.

Reset
REQ-026 On rst_n low, prescaler, PWM counter, shadow, out and period_start SHALL clear to 0 immediately, regardless of clk.
REQ-027 Reset mid-period SHALL abandon the period; after release the first period_start SHALL occur CLK_DIV*256 clk later.
REQ-028 After release, shadow SHALL stay 0 until the first period boundary, so PWM channels SHALL output 0 for the whole first period.

Structure
REQ-029 Shared package SHALL hold CLK_DIV default, PWM_BITS, and NUM_CHANNELS = 16 constants.
REQ-030 Prescaler plus PWM counter SHALL be a sub-module named pwm_timebase exporting step tick, counter value and period_start.
REQ-031 Duty shadow, compare and per-channel output mux SHALL live in pwm_peripheral.

Verification
REQ-032 Scenario: en_out=0xFFFF, en_pwm=0x0000 -> out=0xFFFF 1 clk after enables apply, constant thereafter.
REQ-033 Scenario: en_out=0x0001, en_pwm=0x0001, duty=0x80 -> out[0] high 128*13 clk per 3328 clk period; period_start pulse every 3328 clk.
REQ-034 Scenario: duty 0x00 and 0xFF on channel 15 -> out[15] constant 0 and constant 1 over two full periods.
REQ-035 Scenario: duty changed 0x40 -> 0xC0 mid-period -> current period high time 64*13 clk, next period 192*13 clk.
REQ-036 Scenario: en_pwm=0xFFFF, en_out=0x00FF -> out[15:8]=0 always; out[7:0] identical PWM waveform with no skew.
REQ-037 Scenario: rst_n pulsed low mid-period -> out=0 asynchronously; first period_start 3328 clk after release; PWM outputs 0 until then.
